// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: redirect request, memory-control fetch handshake and decoder output.
// master = instruction_fetch, slave = the surrounding memory control / decoder.
interface instruction_fetch_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  flush, flush_pc, mem_rdy, mem_data, inst_ready,
        output mem_en, mem_addr, inst_valid, inst_out, inst_pc
    );

    modport slave (
        output flush, flush_pc, mem_rdy, mem_data, inst_ready,
        input  mem_en, mem_addr, inst_valid, inst_out, inst_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential fetch stage with an optional direct-mapped one-word-per-line instruction cache.
// Define IFETCH_ICACHE_EN to build the cache; otherwise every lookup goes to memory.
module instruction_fetch #(
    parameter int          CACHE_LINES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input logic                 clk_in,
    input logic                 rst_in,
    input logic                 rdy_in,
    instruction_fetch_if.master bus
);
    typedef enum logic {IDLE, MISS} state_t;

    state_t      state_p0, state_d;
    logic [31:0] pc_p0, pc_d;
    logic        mem_en_p0, mem_en_d;
    logic [31:0] mem_addr_p0, mem_addr_d;
    logic        inst_valid_p1, inst_valid_d;
    logic [31:0] inst_out_p1, inst_out_d;
    logic [31:0] inst_pc_p1, inst_pc_d;
    logic        slot_free;
    logic        hit;
    logic [31:0] hit_data;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

`ifdef IFETCH_ICACHE_EN
    localparam int INDEX_W = $clog2(CACHE_LINES);
    localparam int TAG_W   = 30 - INDEX_W;

    logic [INDEX_W-1:0]     index;
    logic [TAG_W-1:0]       tag;
    logic [CACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]       line_tag  [CACHE_LINES];
    logic [31:0]            line_data [CACHE_LINES];
    logic                   fill_en;

    assign index    = pc_p0[INDEX_W+1:2];
    assign tag      = pc_p0[31:INDEX_W+2];
    assign hit      = line_valid[index] && (line_tag[index] == tag);
    assign hit_data = line_data[index];
    // A fill still lands when a flush coincides with mem_rdy: the word is correct for its address.
    assign fill_en  = rdy_in && (state_p0 == MISS) && bus.mem_rdy;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            line_tag[index]  <= tag;
            line_data[index] <= bus.mem_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign slot_free = !inst_valid_p1 || bus.inst_ready;

    always_comb begin
        state_d      = state_p0;
        pc_d         = pc_p0;
        mem_en_d     = mem_en_p0;
        mem_addr_d   = mem_addr_p0;
        inst_valid_d = inst_valid_p1;
        inst_out_d   = inst_out_p1;
        inst_pc_d    = inst_pc_p1;

        if (bus.flush) begin
            pc_d         = word_align(bus.flush_pc);
            inst_valid_d = 1'b0;
            mem_en_d     = 1'b0;
            state_d      = IDLE;
        end else begin
            if (inst_valid_p1 && bus.inst_ready) begin
                inst_valid_d = 1'b0;
            end
            case (state_p0)
                IDLE: begin
                    if (slot_free) begin
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_out_d   = hit_data;
                            inst_pc_d    = pc_p0;
                            pc_d         = pc_p0 + 32'd4;
                        end else begin
                            state_d    = MISS;
                            mem_en_d   = 1'b1;
                            mem_addr_d = word_align(pc_p0);
                        end
                    end
                end
                MISS: begin
                    // The output slot was empty or drained when the miss started.
                    if (bus.mem_rdy) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = bus.mem_data;
                        inst_pc_d    = pc_p0;
                        pc_d         = pc_p0 + 32'd4;
                        mem_en_d     = 1'b0;
                        state_d      = IDLE;
                    end
                end
            endcase
        end
    end

    // Lookup / request stage (p0) and decoder output register (p1)
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_p0      <= IDLE;
            pc_p0         <= RESET_PC;
            mem_en_p0     <= 1'b0;
            mem_addr_p0   <= '0;
            inst_valid_p1 <= 1'b0;
            inst_out_p1   <= '0;
            inst_pc_p1    <= '0;
        end else if (rdy_in) begin
            state_p0      <= state_d;
            pc_p0         <= pc_d;
            mem_en_p0     <= mem_en_d;
            mem_addr_p0   <= mem_addr_d;
            inst_valid_p1 <= inst_valid_d;
            inst_out_p1   <= inst_out_d;
            inst_pc_p1    <= inst_pc_d;
        end
    end

    assign bus.mem_en     = mem_en_p0;
    assign bus.mem_addr   = mem_addr_p0;
    assign bus.inst_valid = inst_valid_p1;
    assign bus.inst_out   = inst_out_p1;
    assign bus.inst_pc    = inst_pc_p1;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: the program-order reference stream is pushed into a
// queue by the stimulus side and popped by an independent monitor on each decoder handshake.
module tb_instruction_fetch;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    instruction_fetch_if bus ();

    instruction_fetch #(.CACHE_LINES(16), .RESET_PC(32'h0)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] tail_pc;
    int          checks = 0;
    int          errors = 0;
    int          req_cnt = 0;
    int          acc_cnt = 0;
    logic [31:0] last_acc_pc = 32'hDEAD_BEEF;

    bit          pending = 1'b0;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat_min = 0;
    int          lat_max = 0;

    bit          rand_mode = 1'b0;
    bit          k_rdy = 1'b1;
    bit          k_ready = 1'b1;
    bit          k_flush = 1'b0;
    logic [31:0] k_flush_pc = 32'h0;

    // Memory image: an arbitrary address-dependent word, 0x13 at address 0.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[29:0], 2'b00} ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (q.size() < 8) begin
            e.pc   = tail_pc;
            e.data = memf(tail_pc);
            q.push_back(e);
            tail_pc = tail_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] p);
        q.delete();
        tail_pc = p & 32'hFFFF_FFFC;
        refill();
    endtask

    // One cycle: observe the request side, play memory control, drive inputs, advance to edge+1.
    task automatic step();
        bit          r, rd, fl;
        logic [31:0] fpc;
        if (pending) begin
            check("mem_en_held", 32'(bus.mem_en), 32'd1);
            check("mem_addr_held", bus.mem_addr, pend_addr);
        end else if (bus.mem_en) begin
            pending   = 1'b1;
            pend_addr = bus.mem_addr;
            cnt       = $urandom_range(lat_max, lat_min);
            req_cnt++;
            if (q.size() > 0) check("mem_addr", bus.mem_addr, q[0].pc);
        end
        if (rand_mode) begin
            r  = ($urandom_range(9) != 0);
            rd = ($urandom_range(3) != 0);
            fl = r && ($urandom_range(39) == 0);
            fpc = ($urandom_range(1) != 0) ? $urandom
                                           : (($urandom_range(47) << 2) | $urandom_range(3));
        end else begin
            r   = k_rdy;
            rd  = k_ready;
            fl  = k_flush && k_rdy;
            fpc = k_flush_pc;
            k_flush = 1'b0;
        end
        bus.mem_rdy  = 1'b0;
        bus.mem_data = $urandom;
        if (pending && r) begin
            if (cnt == 0) begin
                bus.mem_rdy  = 1'b1;
                bus.mem_data = memf(pend_addr);
                pending      = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (fl) begin
            pending = 1'b0;
            restart(fpc);
        end
        refill();
        rdy_in         = r;
        bus.inst_ready = rd;
        bus.flush      = fl;
        bus.flush_pc   = fl ? fpc : $urandom;
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_acc(input int n, input string name, output int used);
        int target;
        target = acc_cnt + n;
        used   = 0;
        while (acc_cnt < target && used < 60) begin
            step();
            used++;
        end
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, accepted %0d required %0d", name, n - (target - acc_cnt), n);
        end
    endtask

    task automatic flush_to(input logic [31:0] p);
        k_flush    = 1'b1;
        k_flush_pc = p;
        step();
    endtask

    // Monitor: pops the reference stream on every accepted instruction and checks hold stability.
    bit          hold_prev = 1'b0;
    logic [31:0] prev_out, prev_pc;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (hold_prev) begin
                    check("hold_valid", 32'(bus.inst_valid), 32'd1);
                    check("hold_out", bus.inst_out, prev_out);
                    check("hold_pc", bus.inst_pc, prev_pc);
                end
                hold_prev = bus.inst_valid && !bus.inst_ready && !bus.flush;
                prev_out  = bus.inst_out;
                prev_pc   = bus.inst_pc;
                if (bus.inst_valid && bus.inst_ready && !bus.flush && rdy_in) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL queue_empty: got pc %h with nothing expected", bus.inst_pc);
                    end else begin
                        e = q.pop_front();
                        check("inst_pc", bus.inst_pc, e.pc);
                        check("inst_out", bus.inst_out, e.data);
                    end
                    acc_cnt++;
                    last_acc_pc = bus.inst_pc;
                end
            end
        end
    end

    initial begin
        int n, r0, k;
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_pc   = 32'h0;
        bus.mem_rdy    = 1'b0;
        bus.mem_data   = 32'h0;
        bus.inst_ready = 1'b1;
        restart(32'h0);

        repeat (3) @(negedge clk_in);
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_out", bus.inst_out, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("first_mem_en", 32'(bus.mem_en), 32'd1);
        check("first_mem_addr", bus.mem_addr, 32'h0);

        // Fill 0x0..0xC, then rerun the same loop.
        wait_acc(4, "initial_fetch", n);
        flush_to(32'h0);
        r0 = req_cnt;
        wait_acc(4, "loop_reuse", n);
`ifdef IFETCH_ICACHE_EN
        check("loop_cycles", 32'(n), 32'd5);
        check("loop_reqs", 32'(req_cnt - r0), 32'd0);
`else
        check("loop_reqs", 32'(req_cnt - r0), 32'd4);
`endif

        // Backpressure with an instruction parked at the output.
        k_ready = 1'b0;
        flush_to(32'h0);
        k = 0;
        while (!bus.inst_valid && k < 20) begin
            step();
            k++;
        end
        check("bp_valid", 32'(bus.inst_valid), 32'd1);
        repeat (5) step();
        check("bp_pc", bus.inst_pc, 32'h0);
        check("bp_out", bus.inst_out, memf(32'h0));
        k_ready = 1'b1;
        step();
`ifdef IFETCH_ICACHE_EN
        check("bp_next_valid", 32'(bus.inst_valid), 32'd1);
        check("bp_next_pc", bus.inst_pc, 32'h4);
`endif

        // Flush while a miss at 0x100 is outstanding.
        lat_min = 8;
        lat_max = 8;
        flush_to(32'h100);
        k = 0;
        while (!(bus.mem_en && bus.mem_addr == 32'h100) && k < 20) begin
            step();
            k++;
        end
        check("fm_req_0x100", bus.mem_addr, 32'h100);
        flush_to(32'h200);
        check("fm_mem_en_drop", 32'(bus.mem_en), 32'd0);
        k = 0;
        while (!bus.mem_en && k < 20) begin
            step();
            k++;
        end
        check("fm_next_addr", bus.mem_addr, 32'h200);
        lat_min = 0;
        lat_max = 0;
        wait_acc(1, "fm_first", n);

        // Same-index conflict: 0x40 evicts 0x0.
        flush_to(32'h40);
        wait_acc(1, "conflict_fill", n);
        flush_to(32'h0);
        r0 = req_cnt;
        wait_acc(1, "conflict_refetch", n);
        check("conflict_reqs", 32'(req_cnt - r0), 32'd1);

        // PC wrap.
        flush_to(32'hFFFF_FFFC);
        wait_acc(2, "wrap", n);
        check("wrap_pc", last_acc_pc, 32'h0);

        // Randomized traffic.
        lat_max   = 3;
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        k_rdy     = 1'b1;
        k_ready   = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
